// File: rtl/arm_defs_pkg.sv
// arm_defs_pkg: shared encoder state type and immediate field widths
package arm_defs_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  localparam int ROT_FIELD_W  = 4;
  localparam int IMM8_W       = 8;
  localparam int SHIFTER_OP_W = 12;
  localparam int ROT_STEP     = 2;
endpackage

// File: rtl/imm_operand_encoder_if.sv
// imm_operand_encoder_if: start/done request bus of the immediate encoder
interface imm_operand_encoder_if;
  import arm_defs_pkg::*;
  logic                    start;
  logic [31:0]             value;
  logic                    busy;
  logic                    done;
  logic                    valid;
  logic [SHIFTER_OP_W-1:0] shifter_operand;
  modport master (output start, value, input busy, done, valid, shifter_operand);
  modport slave  (input start, value, output busy, done, valid, shifter_operand);
endinterface

// File: rtl/imm_fit_check.sv
// imm_fit_check: tests whether a rotated constant fits in the 8-bit immediate field
module imm_fit_check
  import arm_defs_pkg::*;
(
  input  logic [31:0]       work,
  output logic              hit,
  output logic [IMM8_W-1:0] imm8
);
  assign hit  = work[31:IMM8_W] == '0;
  assign imm8 = work[IMM8_W-1:0];
endmodule

// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: iterative search for the smallest rotate_imm encoding a 32-bit constant
module imm_operand_encoder
  import arm_defs_pkg::*;
#(
  parameter int ROT_STEPS     = 16,
  parameter int ROT_STEP_BITS = ROT_STEP
) (
  input logic clk,
  input logic rst,
  imm_operand_encoder_if.slave bus
);
  state_t                 state, state_nx;
  logic [31:0]            work;
  logic [ROT_FIELD_W-1:0] rot;
  logic                   hit;
  logic [IMM8_W-1:0]      imm8;
  logic                   last;
  imm_fit_check u_fit (.work(work), .hit(hit), .imm8(imm8));
  assign last     = rot == ROT_FIELD_W'(ROT_STEPS - 1);
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (bus.start ? SEARCH : IDLE) :
               state == SEARCH ? ((hit || last) ? DONE : SEARCH) : IDLE;
  end
  // work holds ROL(value, ROT_STEP_BITS*rot), so a fit at rot decodes back by ROR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      work                <= '0;
      rot                 <= '0;
      bus.valid           <= 1'b0;
      bus.shifter_operand <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        work <= bus.value;
        rot  <= '0;
      end else if (state == SEARCH) begin
        if (hit) begin
          bus.shifter_operand <= {rot, imm8};
          bus.valid           <= 1'b1;
        end else if (last) begin
          bus.shifter_operand <= '0;
          bus.valid           <= 1'b0;
        end else begin
          work <= {work[31-ROT_STEP_BITS:0], work[31 -: ROT_STEP_BITS]};
          rot  <= rot + 1'b1;
        end
      end
    end
  end
endmodule
